// File: rtl/shreg_write_arbiter.sv
// ---------------------------------------------------------------------------
// shreg_write_arbiter
//
// Round-robin write arbiter in front of one shared DATA_W-bit register.
// At most one requester is granted per clock. The granted datum becomes
// reg_q, the old value moves to prev_q, and upd_valid/upd_id report where
// the update came from. The requester granted last cycle is masked for one
// cycle (eff_req = req & ~gnt). This gives it time to drop req without being
// granted twice.
//
// Optional feature, enabled by defining SHREG_COLLISION_CNT_EN:
//   collision_cnt is a saturating count of the cycles in which two or more
//   effective requests competed for the register.
// ---------------------------------------------------------------------------
module shreg_write_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int CNT_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       freeze,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*DATA_W-1:0]  wdata,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [DATA_W-1:0]          reg_q,
    output logic [DATA_W-1:0]          prev_q,
    output logic                       upd_valid,
    output logic [$clog2(NUM_REQ)-1:0] upd_id
`ifdef SHREG_COLLISION_CNT_EN
    ,
    output logic [CNT_W-1:0]           collision_cnt
`endif
);

    localparam int               IDX_W    = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    // Reject parameter values the pointer arithmetic was not built for.
    if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
        $error("shreg_write_arbiter: NUM_REQ must be in 2..16");
    end
    if (DATA_W < 1) begin : g_bad_data_w
        $error("shreg_write_arbiter: DATA_W must be at least 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("shreg_write_arbiter: CNT_W must be at least 1");
    end

    // Round-robin pointer: the first requester index considered next cycle.
    logic [IDX_W-1:0]   rr_ptr;

    logic [NUM_REQ-1:0] eff_req;
    logic               any_req;
    logic               do_grant;
    logic [IDX_W-1:0]   win;

    logic [NUM_REQ-1:0] nxt_gnt;
    logic [DATA_W-1:0]  nxt_reg_q;
    logic [DATA_W-1:0]  nxt_prev_q;
    logic               nxt_upd_valid;
    logic [IDX_W-1:0]   nxt_upd_id;
    logic [IDX_W-1:0]   nxt_rr_ptr;

    // Last cycle's winner sits out one cycle, so a slow req drop is harmless.
    assign eff_req  = req & ~gnt;
    assign any_req  = |eff_req;
    assign do_grant = any_req && !freeze;

    // Winner search: first set bit of eff_req, scanning upward from rr_ptr
    // and wrapping NUM_REQ-1 -> 0.
    always_comb begin
        int               idx;
        logic [IDX_W-1:0] cand;
        logic             found;
        // NOTE: every variable written here gets a default before any branch,
        // so no path leaves a value unassigned and no latch is inferred.
        win   = '0;
        found = 1'b0;
        idx   = 0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = IDX_W'(idx);
            if (!found && eff_req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Next-state for the register, grant, provenance and pointer.
    always_comb begin
        // NOTE: combinational logic uses blocking '=' so later statements see
        // the updated value; the registers below use non-blocking '<=' so
        // all flops update together on the edge.
        nxt_gnt       = '0;
        nxt_upd_valid = 1'b0;
        nxt_reg_q     = reg_q;
        nxt_prev_q    = prev_q;
        nxt_upd_id    = upd_id;
        nxt_rr_ptr    = rr_ptr;
        if (do_grant) begin
            nxt_gnt[win]  = 1'b1;
            nxt_upd_valid = 1'b1;
            nxt_reg_q     = wdata[int'(win)*DATA_W +: DATA_W];
            nxt_prev_q    = reg_q;
            nxt_upd_id    = win;
            // Explicit compare keeps the wrap right for non-power-of-2 counts.
            nxt_rr_ptr    = (win == LAST_IDX) ? '0 : win + IDX_W'(1);
        end
    end

    // State register. A synchronous reset clears every flop and discards any
    // request that is pending in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt       <= '0;
            reg_q     <= '0;
            prev_q    <= '0;
            upd_valid <= 1'b0;
            upd_id    <= '0;
            rr_ptr    <= '0;
        end else begin
            gnt       <= nxt_gnt;
            reg_q     <= nxt_reg_q;
            prev_q    <= nxt_prev_q;
            upd_valid <= nxt_upd_valid;
            upd_id    <= nxt_upd_id;
            rr_ptr    <= nxt_rr_ptr;
        end
    end

`ifdef SHREG_COLLISION_CNT_EN
    logic multi_req;

    // Two or more bits are set exactly when clearing the lowest set bit
    // leaves something behind.
    assign multi_req = |(eff_req & (eff_req - NUM_REQ'(1)));

    // Saturating collision counter. It is held while frozen.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            collision_cnt <= '0;
        end else if (!freeze && multi_req && (collision_cnt != '1)) begin
            collision_cnt <= collision_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_shreg_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_shreg_write_arbiter
//
// Directed bench for shreg_write_arbiter (NUM_REQ=4, DATA_W=8, CNT_W=2).
// Inputs change 1 ns after a rising edge. Outputs are checked 1 ns after the
// next rising edge, so each check sees the result of the inputs set before it.
// The collision counter checks are compiled only when SHREG_COLLISION_CNT_EN
// is defined.
// ---------------------------------------------------------------------------
module tb_shreg_write_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int CNT_W   = 2;

    logic                      clk;
    logic                      rst_n;
    logic                      freeze;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [DATA_W-1:0]         reg_q;
    logic [DATA_W-1:0]         prev_q;
    logic                      upd_valid;
    logic [1:0]                upd_id;
`ifdef SHREG_COLLISION_CNT_EN
    logic [CNT_W-1:0]          collision_cnt;
`endif

    int total = 0;
    int bad   = 0;

    shreg_write_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .freeze        (freeze),
        .req           (req),
        .wdata         (wdata),
        .gnt           (gnt),
        .reg_q         (reg_q),
        .prev_q        (prev_q),
        .upd_valid     (upd_valid),
        .upd_id        (upd_id)
`ifdef SHREG_COLLISION_CNT_EN
        ,
        .collision_cnt (collision_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check every architectural output in one call.
    task automatic check_all(input string tag, input logic [3:0] e_gnt,
                             input logic [7:0] e_reg, input logic [7:0] e_prev,
                             input logic e_valid, input logic [1:0] e_id);
        check({tag, ".gnt"},       32'(gnt),       32'(e_gnt));
        check({tag, ".reg_q"},     32'(reg_q),     32'(e_reg));
        check({tag, ".prev_q"},    32'(prev_q),    32'(e_prev));
        check({tag, ".upd_valid"}, 32'(upd_valid), 32'(e_valid));
        check({tag, ".upd_id"},    32'(upd_id),    32'(e_id));
    endtask

    initial begin
        // Reset with junk on the inputs for three cycles.
        rst_n  = 1'b0;
        freeze = 1'b0;
        req    = 4'b1111;
        wdata  = 32'hDEAD_BEEF;
        tick(); tick(); tick();
        check_all("reset", 4'b0000, 8'd0, 8'd0, 1'b0, 2'd0);
`ifdef SHREG_COLLISION_CNT_EN
        check("reset.cnt", 32'(collision_cnt), 32'd0);
`endif

        // Release with no requests: everything stays at zero.
        rst_n = 1'b1;
        req   = 4'b0000;
        wdata = 32'h0;
        tick(); tick();
        check_all("idle", 4'b0000, 8'd0, 8'd0, 1'b0, 2'd0);

        // Single writer on requester 2. rr_ptr moves to 3.
        req   = 4'b0100;
        wdata = 32'd20 << 16;
        tick();
        check_all("single", 4'b0100, 8'd20, 8'd0, 1'b1, 2'd2);
        req = 4'b0000;
        tick();
        check_all("single_after", 4'b0000, 8'd20, 8'd0, 1'b0, 2'd2);

        // Simultaneous writers 0 and 1. The search from 3 wraps to 0 first.
        req   = 4'b0011;
        wdata = {8'd0, 8'd0, 8'd20, 8'd10};
        tick();
        check_all("sim_first", 4'b0001, 8'd10, 8'd20, 1'b1, 2'd0);
`ifdef SHREG_COLLISION_CNT_EN
        check("sim.cnt", 32'(collision_cnt), 32'd1);
`endif
        req = 4'b0010;
        tick();
        check_all("sim_second", 4'b0010, 8'd20, 8'd10, 1'b1, 2'd1);
        req = 4'b0000;
        tick();
        check_all("sim_idle", 4'b0000, 8'd20, 8'd10, 1'b0, 2'd1);

        // A reset in the middle of a stream grants nothing and clears rr_ptr.
        req   = 4'b1111;
        wdata = 32'hA3A2_A1A0;
        rst_n = 1'b0;
        tick();
        check_all("mid_reset", 4'b0000, 8'd0, 8'd0, 1'b0, 2'd0);

        // Rotation with all four requesting: 0,1,2,3 and then a wrap to 0.
        rst_n = 1'b1;
        tick();
        check_all("rot0", 4'b0001, 8'hA0, 8'h00, 1'b1, 2'd0);
        tick();
        check_all("rot1", 4'b0010, 8'hA1, 8'hA0, 1'b1, 2'd1);
        tick();
        check_all("rot2", 4'b0100, 8'hA2, 8'hA1, 1'b1, 2'd2);
        tick();
        check_all("rot3", 4'b1000, 8'hA3, 8'hA2, 1'b1, 2'd3);
        tick();
        check_all("rot_wrap", 4'b0001, 8'hA0, 8'hA3, 1'b1, 2'd0);

        // Freeze for five cycles with requester 3 pending: no grants, state held.
        freeze = 1'b1;
        req    = 4'b1000;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_all($sformatf("freeze%0d", i), 4'b0000, 8'hA0, 8'hA3, 1'b0, 2'd0);
        end
        freeze = 1'b0;
        tick();
        check_all("unfreeze", 4'b1000, 8'hA3, 8'hA0, 1'b1, 2'd3);
        req = 4'b0000;
        tick();
        check_all("unfreeze_idle", 4'b0000, 8'hA3, 8'hA0, 1'b0, 2'd3);

        // A write equal to the current value still counts as an update.
        req = 4'b1000;
        tick();
        check_all("same_val", 4'b1000, 8'hA3, 8'hA3, 1'b1, 2'd3);
        req = 4'b0000;
        tick();

        // A req held after the grant: masked one cycle, then granted again.
        req = 4'b0001;
        tick();
        check_all("hold_g1", 4'b0001, 8'hA0, 8'hA3, 1'b1, 2'd0);
        tick();
        check_all("hold_mask", 4'b0000, 8'hA0, 8'hA3, 1'b0, 2'd0);
        tick();
        check_all("hold_g2", 4'b0001, 8'hA0, 8'hA0, 1'b1, 2'd0);
        req = 4'b0000;
        tick();

`ifdef SHREG_COLLISION_CNT_EN
        // Saturation: req=0111 keeps at least two effective requests every
        // cycle, so the 2-bit count reaches 3 and stays there.
        rst_n = 1'b0;
        tick();
        check("sat.reset", 32'(collision_cnt), 32'd0);
        rst_n = 1'b1;
        req   = 4'b0111;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check($sformatf("sat%0d", i), 32'(collision_cnt), (i > 3) ? 32'd3 : 32'(i));
        end
        rst_n = 1'b0;
        tick();
        check("sat.mid_reset", 32'(collision_cnt), 32'd0);
        rst_n = 1'b1;
        req   = 4'b0000;
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shreg_write_arbiter.md
Name: shreg_write_arbiter

Overview:
- Round-robin write arbiter that shares one DATA_W-bit register between NUM_REQ requesters.
- Accepts at most one write per clock, so simultaneous writers never race and last-write-wins ambiguity inside a cycle cannot occur.
- Publishes the current value, the previous value and update provenance.
- Sits between the requesting agents and any logic consuming the shared value.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- DATA_W, 8, width of the shared register and of each write datum
- CNT_W, 8, width of the collision counter (optional feature only)

Ports:
- clk  in  1  single clock, all logic on posedge
- rst_n  in  1  synchronous reset, active-low, sampled on posedge clk
- freeze  in  1  when 1: no grants, register held, pointer held
- req  in  NUM_REQ  write request per requester, level, held until granted
- wdata  in  NUM_REQ*DATA_W  write data; slice i = wdata[i*DATA_W +: DATA_W]
- gnt  out  NUM_REQ  one-hot registered grant, one-cycle pulse
- reg_q  out  DATA_W  current shared register value
- prev_q  out  DATA_W  value of reg_q before the most recent update
- upd_valid  out  1  one-cycle pulse: reg_q changed source this cycle
- upd_id  out  $clog2(NUM_REQ)  index of the last granted requester
- collision_cnt  out  CNT_W  saturating collision count (SHREG_COLLISION_CNT_EN only)

Behaviour:
- Reset values when rst_n=0 at posedge:
  - reg_q=0, prev_q=0, gnt=0, upd_valid=0, upd_id=0, rr_ptr=0, collision_cnt=0.
  - Reset asserted mid-stream discards any pending request; nothing is granted that cycle.
- Effective request: eff_req = req & ~gnt. The requester granted last cycle is masked for exactly one cycle, which prevents a double grant while it drops req.
- Requester rule: deassert req, or present new data, on the cycle after sampling gnt=1. A req still high after the masked cycle is treated as a new request.
- Arbitration, each posedge with rst_n=1, freeze=0 and eff_req!=0:
  - Winner w = first set bit of eff_req, searching upward from rr_ptr with wrap NUM_REQ-1 -> 0.
  - Registered updates: reg_q<=wdata[w]; prev_q<=reg_q (old value); gnt<=onehot(w); upd_valid<=1; upd_id<=w.
  - rr_ptr<=(w+1) mod NUM_REQ.
- Latency: req sampled at edge N; reg_q, gnt and upd_valid valid after edge N (visible in cycle N+1).
- Write equal to current value: update still occurs. prev_q<=reg_q and upd_valid=1; there is no value-compare suppression.
- Idle (eff_req=0): gnt<=0, upd_valid<=0. reg_q, prev_q, upd_id and rr_ptr are held.
- Freeze=1:
  - gnt<=0 and upd_valid<=0; all state held.
  - The mask uses gnt, so after freeze the previous winner is re-eligible.
  - Requests stay pending, with no loss, until freeze drops.
- Fairness: with all NUM_REQ requesting continuously, grants rotate 0,1,2,...,NUM_REQ-1,0. A continuously requesting agent waits at most NUM_REQ-1 cycles.
- Width rules:
  - rr_ptr and upd_id are $clog2(NUM_REQ) bits.
  - The wrap uses explicit compare to NUM_REQ-1, so it is correct for non-power-of-2 NUM_REQ.

Optional Feature:
- Macro: SHREG_COLLISION_CNT_EN.
- When defined:
  - collision_cnt increments by 1 at each posedge where rst_n=1, freeze=0 and popcount(eff_req)>=2.
  - It saturates at 2^CNT_W-1 with no wrap, and is reset to 0 by rst_n.
- When undefined:
  - The collision_cnt port and counter logic are absent.
  - All other behaviour is identical.

Test Plan:
- Reset: drive junk on req/wdata, rst_n=0 for 3 cycles -> reg_q=0, prev_q=0, gnt=0, upd_valid=0; after release with req=0 all outputs remain 0.
- Single writer: req=4'b0100, wdata slice2=8'd20 for 1 cycle -> next cycle gnt=4'b0100, reg_q=20, prev_q=0, upd_id=2, upd_valid=1; following cycle upd_valid=0, reg_q=20.
- Simultaneous writers: req=4'b0011, slice0=10, slice1=20, each requester dropping req after its gnt -> gnt=0001 (reg_q=10), then gnt=0010 (reg_q=20, prev_q=10); collision_cnt=1 if enabled.
- Rotation and wrap: req=4'b1111 held continuously -> gnt sequence 0001,0010,0100,1000,0001, with no requester granted two consecutive cycles.
- Freeze: freeze=1 with req=4'b1000 for 5 cycles -> gnt=0, reg_q unchanged; freeze=0 -> gnt=1000 on the next cycle.
- Saturation (enabled, CNT_W=2): 5 collision cycles -> collision_cnt=3 and stays 3; reset mid-stream -> 0.
